// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//
// Contents:
//   fetch_state_t  - request/response sequencer states
//   OPCODE_*       - position of the opcode field that feeds the control unit
//   NOP_INSTR      - all-zero bubble; opcode 000000 is never decoded
//   fetch_entry_t  - one fetched instruction and the address it came from
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam int OPCODE_MSB = FETCH_INSTR_W - 1;
    localparam int OPCODE_LSB = FETCH_INSTR_W - 6;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched instruction while decode is
// stalled and the IF/ID register is already occupied.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write din into the entry (marks it full)
//   pop         - release the entry (ignored when push is also set)
//   flush       - discard the entry; wins over push and pop
//   din / dout  - entry contents
//   full        - entry holds live data
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_INSTR_W + FETCH_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    // A simultaneous push and pop replaces the entry and leaves it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            dout <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the control unit.
//
// Owns the PC, issues one instruction-memory request at a time, drops
// responses that a branch redirect has made stale, and presents fetched
// instructions in the IF/ID register. A one-entry skid buffer catches a
// response that lands while decode is stalled with IF/ID occupied.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       - fetch request handshake (addr = pc)
//   imem_rsp_valid/data             - one in-order response per request
//   redirect_valid, redirect_pc     - taken branch/jump from execute
//   stall                           - decode cannot accept this cycle
//   id_valid, id_instr, id_opcode   - IF/ID contents; opcode drives control
//   id_pc, id_pc_next               - address of id_instr and that + PC_STEP
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                stall,
    output logic                id_valid,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [OPCODE_W-1:0] id_opcode,
    output logic [ADDR_W-1:0]   id_pc,
    output logic [ADDR_W-1:0]   id_pc_next
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               req_fire;
    logic               deliver;

    logic               skid_full;
    logic               skid_push;
    logic               skid_pop;
    logic [ENTRY_W-1:0] skid_dout;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    logic               id_load;
    logic               id_from_skid;
    logic [INSTR_W-1:0] load_instr;
    logic [ADDR_W-1:0]  load_pc;

    assign imem_req_addr = pc;
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign {skid_instr, skid_pc} = skid_dout;
    assign id_opcode     = id_instr[INSTR_W-1 -: OPCODE_W];

    // Sequencer: a request is only offered while nothing is outstanding,
    // the skid has room and no redirect is replacing the pc. In S_WAIT a
    // redirect that coincides with the response simply discards it and
    // returns to S_REQ, since no further response for that request exists.
    always_comb begin
        imem_req_valid = 1'b0;
        deliver        = 1'b0;
        state_nxt      = state;
        case (state)
            S_REQ: begin
                imem_req_valid = rst_n && !skid_full && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    state_nxt = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    deliver   = !redirect_valid;
                    state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // State, pc and the address of the request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (req_fire) begin
                pc <= pc + PC_STEP;
            end
            if (req_fire) begin
                req_pc <= pc;
            end
        end
    end

    // Steering of each delivered instruction. The skid is always older
    // than a same-cycle delivery, so it drains into IF/ID first; the skid
    // only fills while IF/ID is occupied and decode is stalled.
    always_comb begin
        id_load      = 1'b0;
        id_from_skid = 1'b0;
        skid_push    = 1'b0;
        skid_pop     = 1'b0;
        if (!redirect_valid) begin
            if (!stall) begin
                if (skid_full) begin
                    id_load      = 1'b1;
                    id_from_skid = 1'b1;
                    skid_pop     = 1'b1;
                    skid_push    = deliver;
                end else if (deliver) begin
                    id_load = 1'b1;
                end
            end else if (deliver) begin
                if (!id_valid) begin
                    id_load = 1'b1;
                end else begin
                    skid_push = 1'b1;
                end
            end
        end
        load_instr = id_from_skid ? skid_instr : imem_rsp_data;
        load_pc    = id_from_skid ? skid_pc    : req_pc;
    end

    fetch_skid_buf #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (skid_push),
        .pop   (skid_pop),
        .flush (redirect_valid),
        .din   ({imem_rsp_data, req_pc}),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    // IF/ID register. A redirect kills the entry and zeroes the instruction
    // so the control unit sees a bubble; the pc fields are left as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_instr   <= INSTR_W'(NOP_INSTR);
            id_pc      <= '0;
            id_pc_next <= '0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            id_instr <= INSTR_W'(NOP_INSTR);
        end else if (id_load) begin
            id_valid   <= 1'b1;
            id_instr   <= load_instr;
            id_pc      <= load_pc;
            id_pc_next <= load_pc + PC_STEP;
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. The reference is a transaction-level view: the
// instruction stream seen at IF/ID must be the sequential program starting
// at the last reset/redirect target, the number of live fetched-but-not-
// consumed instructions decides id_valid and request eligibility, and every
// accepted request must be for the next sequential fetch address.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [31:0] id_pc;
    logic [31:0] id_pc_next;

    int total;
    int bad;

    // Reference state
    bit          mem_pending;
    int          mem_delay;
    logic [31:0] mem_addr;
    int          mem_epoch;
    int          epoch;
    int          buffered;
    logic [31:0] exp_pc;
    logic [31:0] req_exp;
    bit          last_redirect;
    bit          stray;
    int          lat_fixed;
    int          lat_max;
    int          consumed;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_pc          (id_pc),
        .id_pc_next     (id_pc_next)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a | 32'h0400_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("[TB] FAIL %s observed=timeout expected=condition reached", tag);
    endtask

    task automatic model_reset();
        mem_pending   = 1'b0;
        mem_delay     = 0;
        buffered      = 0;
        exp_pc        = 32'h0;
        req_exp       = 32'h0;
        last_redirect = 1'b0;
        epoch++;
    endtask

    task automatic check_reset_outputs();
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_pc_next", id_pc_next, 32'h0);
        check("rst_req_valid", imem_req_valid, 1'b0);
    endtask

    task automatic check_outputs();
        fetch_entry_t head;
        logic [31:0]  exp_next;
        logic [5:0]   exp_op;
        bit           exp_req_valid;
        exp_req_valid = !mem_pending && buffered < 2 && !redirect_valid;
        check("req_valid", imem_req_valid, exp_req_valid);
        if (exp_req_valid) check("req_addr", imem_req_addr, req_exp);
        check("id_valid", id_valid, buffered != 0);
        if (buffered != 0) begin
            head.pc    = exp_pc;
            head.instr = memf(exp_pc);
            exp_next   = exp_pc + 32'd4;
            exp_op     = head.instr[31:26];
            check("id_pc", id_pc, head.pc);
            check("id_instr", id_instr, head.instr);
            check("id_opcode", id_opcode, exp_op);
            check("id_pc_next", id_pc_next, exp_next);
        end else if (last_redirect) begin
            check("id_instr_flushed", id_instr, 32'h0);
        end
    endtask

    // One clock cycle: drive the memory response, compare the outputs,
    // then advance the reference across the coming rising edge.
    task automatic tick();
        bit hs;
        bit rsp_real;
        bit live;
        int lat;
        rsp_real       = mem_pending && mem_delay == 0;
        imem_rsp_valid = rsp_real || stray;
        imem_rsp_data  = stray ? 32'hDEAD_BEEF : memf(mem_addr);
        #1;
        check_outputs();
        hs   = !mem_pending && buffered < 2 && !redirect_valid && imem_req_ready;
        live = rsp_real && mem_epoch == epoch && !redirect_valid;
        if (redirect_valid) begin
            buffered = 0;
            exp_pc   = redirect_pc;
            req_exp  = redirect_pc;
            epoch++;
        end else begin
            if (buffered != 0 && !stall) begin
                buffered--;
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (live) buffered++;
        end
        if (rsp_real) mem_pending = 1'b0;
        else if (mem_pending) mem_delay--;
        if (hs) begin
            lat         = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, lat_max));
            mem_pending = 1'b1;
            mem_delay   = lat - 1;
            mem_addr    = req_exp;
            mem_epoch   = epoch;
            req_exp     = req_exp + 32'd4;
        end
        last_redirect = redirect_valid;
        @(posedge clk);
        @(negedge clk);
        stray = 1'b0;
    endtask

    initial begin
        int n;
        total          = 0;
        bad            = 0;
        epoch          = 0;
        mem_epoch      = 0;
        mem_addr       = 32'h0;
        consumed       = 0;
        stray          = 1'b0;
        lat_fixed      = 1;
        lat_max        = 1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Free-running fetch from RESET_PC with an always-ready memory.
        repeat (8) tick();

        // Stall long enough for the skid to fill, then release.
        stall = 1'b1;
        repeat (4) tick();
        stall = 1'b0;
        repeat (6) tick();

        // Redirect while a two-cycle response is still in flight.
        lat_fixed = 2;
        n = 0;
        while (!(mem_pending && mem_delay > 0) && n < 10) begin
            tick();
            n++;
        end
        if (!(mem_pending && mem_delay > 0)) timeout_fail("wait_s_wait");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        lat_fixed = 1;

        // Fill IF/ID and skid under stall, then redirect with stall held.
        stall = 1'b1;
        n = 0;
        while (buffered != 2 && n < 12) begin
            tick();
            n++;
        end
        if (buffered != 2) timeout_fail("wait_skid_full");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        repeat (8) tick();

        // Memory not ready for three cycles.
        imem_req_ready = 1'b0;
        repeat (3) tick();
        imem_req_ready = 1'b1;
        repeat (4) tick();

        // Address wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();

        // Asynchronous reset while waiting, then a stray late response.
        lat_fixed = 2;
        n = 0;
        while (!mem_pending && n < 10) begin
            tick();
            n++;
        end
        if (!mem_pending) timeout_fail("wait_pending");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        lat_fixed = 1;
        stray     = 1'b1;
        tick();
        repeat (6) tick();

        // Randomized traffic: ready, stall, redirects and latency all vary.
        lat_fixed = 0;
        lat_max   = 2;
        for (int i = 0; i < 600; i++) begin
            imem_req_ready = ($urandom_range(0, 9) < 7);
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (6) tick();

        check("progress", consumed >= 60, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the control unit. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and discards responses made stale by a branch redirect. It presents each fetched instruction in an IF/ID register, whose opcode field [31:26] drives the control unit. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width; opcode = instr[INSTR_W-1 -: 6]
RESET_PC, 0, PC value after reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address (= pc)
imem_rsp_valid  in  1  response valid, one cycle per accepted request, in order
imem_rsp_data  in  INSTR_W  fetched instruction
redirect_valid  in  1  taken branch/jump from execute (pc_src)
redirect_pc  in  ADDR_W  branch target
stall  in  1  decode cannot accept; hold IF/ID
id_valid  out  1  IF/ID holds a live instruction
id_instr  out  INSTR_W  instruction to decode
id_opcode  out  6  id_instr[INSTR_W-1 -: 6], to control unit
id_pc  out  ADDR_W  address of id_instr
id_pc_next  out  ADDR_W  id_pc + PC_STEP

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_REQ, skid empty, id_valid=0, id_instr=0, id_pc=0, id_pc_next=0, imem_req_valid=0. Opcode 000000 is a bubble and is undecoded.
- FSM states: S_REQ, S_WAIT, S_DROP.
- S_REQ: imem_req_valid=1 iff skid empty and no redirect this cycle. On handshake: req_pc<=pc, pc<=pc+PC_STEP (wraps mod 2^ADDR_W), go to S_WAIT.
- S_WAIT: imem_req_valid=0. On imem_rsp_valid, deliver {data, req_pc} and go to S_REQ.
- Delivery: if !id_valid or !stall, load the IF/ID register (id_valid=1). Otherwise write the skid buffer. Back-to-back throughput is one instruction per 2 cycles (request, then response).
- IF/ID drain: when !stall, IF/ID loads from the skid if it is full, else from a same-cycle delivery, else id_valid<=0. When stall && id_valid, all id_* outputs hold.
- Redirect has top priority: pc<=redirect_pc; id_valid<=0; skid cleared; id_instr zeroed.
  - In S_WAIT, or S_REQ with a same-cycle handshake, go to S_DROP.
  - In S_REQ without handshake, stay in S_REQ. imem_req_valid is deasserted that cycle; the new pc is requested next cycle.
  - In S_DROP, stay in S_DROP with pc updated.
  - Redirect overrides a simultaneous stall.
- S_DROP: imem_req_valid=0. The next imem_rsp_valid is discarded (not delivered), then go to S_REQ. A redirect in the same cycle as the discarded response goes to S_REQ with the new pc.
- imem_rsp_valid in S_REQ is a protocol error and is ignored.
- Ready low: imem_req_valid and imem_req_addr hold stable until the handshake.

Decomposition:
- fetch_pkg: state enum (S_REQ, S_WAIT, S_DROP), OPCODE_MSB/LSB constants, NOP_INSTR = 0, fetch_entry_t struct {instr, pc}.
- Sub-module fetch_skid_buf: one-entry buffer with push/pop/flush and full flag.

Test Plan:
- Reset, then memory always ready with data=addr|0x04000000: requests at 0, 4, 8. id_pc sequence is 0, 4, 8 at 2-cycle spacing; id_opcode=000001.
- Stall held for 4 cycles while a response arrives: IF/ID holds pc 4, skid takes pc 8, no new request is issued. On release, pc 8 appears in the next cycle, then fetch resumes at 0xC.
- Redirect to 0x100 in S_WAIT: the response for 0x8 is discarded, the next request address is 0x100, and id_valid=0 during the gap.
- Redirect and stall in the same cycle with IF/ID and skid both full: both are flushed, and id_pc=0x100 is the first valid entry.
- imem_req_ready low for 3 cycles: address 0x10 is held stable, and pc advances only on the handshake.
- pc=0xFFFFFFFC with ADDR_W=32: the next request address wraps to 0x0, and id_pc_next=0x0.
- Async reset asserted in S_WAIT: outputs clear immediately; after release the first request is at RESET_PC, and any late response is ignored in S_REQ.
